// File: rtl/aes_key_expand_if.sv
// Key-in / round-key-out handshake bundle for aes_key_expand.
// slave is the key-schedule side, master is the upstream/downstream side.
interface aes_key_expand_if;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk;
   logic [3:0]   rk_idx;
   logic         rk_last;
   logic         busy;

   modport master (
      output key_valid, key, rk_ready,
      input  key_ready, rk_valid, rk, rk_idx, rk_last, busy
   );

   modport slave (
      input  key_valid, key, rk_ready,
      output key_ready, rk_valid, rk, rk_idx, rk_last, busy
   );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per handshake, one SubWord per cycle.
// Optional round-key store for replay is enabled by defining AES_KEYEXP_STORE_EN.
module aes_key_expand #(
   parameter int unsigned NR = 10
) (
   input  logic             clk,
   input  logic             rst,
   aes_key_expand_if.slave  bus
`ifdef AES_KEYEXP_STORE_EN
   ,
   input  logic [3:0]       rd_idx,
   output logic [127:0]     rd_rk
`endif
);

   localparam logic [3:0] LAST_IDX = 4'(NR);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t       state;
   logic         key_ready_q;
   logic         rk_valid_q;
   logic         busy_q;
   logic [127:0] rk_q;
   logic [3:0]   idx_q;
   logic         last_q;
   logic [7:0]   rcon_q;

   logic         accept;
   logic         advance;
   logic [31:0]  w0, w1, w2, w3, t, n0, n1, n2, n3;
   logic [127:0] next_rk;

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] s;
      s = 8'h00;
      case (a)
         8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
         8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
         8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
         8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
         8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
         8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
         8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
         8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
         8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
         8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
         8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
         8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
         8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
         8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
         8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
         8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
         8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
         8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
         8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
         8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
         8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
         8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
         8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
         8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
         8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
         8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
         8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
         8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
         8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
         8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
         8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
         8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      endcase
      return s;
   endfunction

   assign accept  = bus.key_valid & key_ready_q;
   assign advance = (state == EMIT) & bus.rk_ready & (idx_q != LAST_IDX);

   // One expansion step: SubWord(RotWord(w3)) ^ rcon, then the xor chain across words.
   assign {w0, w1, w2, w3} = rk_q;
   assign t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon_q, 24'h0};
   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign next_rk = {n0, n1, n2, n3};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         key_ready_q <= 1'b1;
         rk_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         rk_q        <= '0;
         idx_q       <= '0;
         last_q      <= 1'b0;
         rcon_q      <= 8'h01;
      end else begin
         case (state)
            IDLE: if (accept) begin
               state       <= EMIT;
               key_ready_q <= 1'b0;
               rk_valid_q  <= 1'b1;
               busy_q      <= 1'b1;
               rk_q        <= bus.key;
               idx_q       <= '0;
               last_q      <= 1'b0;
               rcon_q      <= 8'h01;
            end
            EMIT: if (bus.rk_ready) begin
               if (idx_q == LAST_IDX) begin
                  // Final key consumed; rk/rk_idx stay visible for the datapath.
                  state       <= IDLE;
                  key_ready_q <= 1'b1;
                  rk_valid_q  <= 1'b0;
                  busy_q      <= 1'b0;
                  last_q      <= 1'b0;
               end else begin
                  rk_q   <= next_rk;
                  idx_q  <= idx_q + 4'd1;
                  last_q <= (idx_q + 4'd1) == LAST_IDX;
                  rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.key_ready = key_ready_q;
   assign bus.rk_valid  = rk_valid_q;
   assign bus.busy      = busy_q;
   assign bus.rk        = rk_q;
   assign bus.rk_idx    = idx_q;
   assign bus.rk_last   = last_q;

`ifdef AES_KEYEXP_STORE_EN
   logic [127:0] store [NR+1];

   // Entry i is written alongside the load of round key i; cleared on each new key.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i <= NR; i++) store[i] <= '0;
      end else if (accept) begin
         for (int unsigned i = 0; i <= NR; i++) store[i] <= (i == 0) ? bus.key : '0;
      end else if (advance) begin
         for (int unsigned i = 0; i <= NR; i++) begin
            if (4'(i) == idx_q + 4'd1) store[i] <= next_rk;
         end
      end
   end

   always_comb begin
      rd_rk = '0;
      for (int unsigned i = 0; i <= NR; i++) begin
         if (rd_idx == 4'(i)) rd_rk = store[i];
      end
   end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed, table-driven bench for aes_key_expand (FIPS-197 vectors, stalls, abort, store).
module tb_aes_key_expand;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] Z1 = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   typedef struct {
      logic [127:0] key;
      int           mode;
      int           idx;
      logic [127:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   aes_key_expand_if bus ();
`ifdef AES_KEYEXP_STORE_EN
   logic [3:0]   rd_idx = 4'd0;
   logic [127:0] rd_rk;
`endif

   aes_key_expand #(.NR(10)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef AES_KEYEXP_STORE_EN
      ,
      .rd_idx(rd_idx),
      .rd_rk(rd_rk)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [127:0] fips [11];
   logic [127:0] got [11];
   logic [3:0]   got_idx [11];
   logic         got_last [11];
   vec_t         vecs [24];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Offer key k, then consume all round keys; mode 1 drives rk_ready as 1,0,0,1 repeating.
   task automatic run_key(input logic [127:0] k, input int mode, input string tag);
      int t, n, vcyc;
      logic rdy, stalled, seq_ok;
      logic [127:0] prev_rk;
      logic [3:0] prev_idx;
      logic [3:0] pat;
      pat = 4'b1001;
      n = 0; vcyc = 0; stalled = 1'b0; prev_rk = '0; prev_idx = '0;
      @(negedge clk);
      bus.rk_ready = 1'b0; bus.key = k; bus.key_valid = 1'b1;
      t = 0;
      while (!bus.key_ready && t < 100) begin @(negedge clk); t++; end
      if (!bus.key_ready) begin
         chk({tag, " accept_timeout"}, 128'(bus.key_ready), 128'(1));
         bus.key_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.key_valid = 1'b0;
      for (int cyc = 0; cyc < 200 && n < 11; cyc++) begin
         if (stalled) begin
            chk({tag, " stall_rk"}, bus.rk, prev_rk);
            chk({tag, " stall_idx"}, 128'(bus.rk_idx), 128'(prev_idx));
         end
         rdy = (mode == 0) ? 1'b1 : pat[cyc % 4];
         bus.rk_ready = rdy;
         if (bus.rk_valid) begin
            vcyc++;
            if (rdy) begin
               got[n] = bus.rk; got_idx[n] = bus.rk_idx; got_last[n] = bus.rk_last;
               n++;
            end
         end
         stalled = bus.rk_valid & !rdy;
         prev_rk = bus.rk; prev_idx = bus.rk_idx;
         @(negedge clk);
      end
      bus.rk_ready = 1'b0;
      chk({tag, " count"}, 128'(n), 128'(11));
      seq_ok = (n == 11);
      for (int i = 0; i < n; i++) begin
         if (got_idx[i] != 4'(i) || got_last[i] != (i == 10)) seq_ok = 1'b0;
      end
      chk({tag, " idx_last_seq"}, 128'(seq_ok), 128'(1));
      if (mode == 0) chk({tag, " valid_cycles"}, 128'(vcyc), 128'(11));
      chk({tag, " post_valid"}, 128'(bus.rk_valid), 128'(0));
      chk({tag, " post_ready"}, 128'(bus.key_ready), 128'(1));
      chk({tag, " post_busy"}, 128'(bus.busy), 128'(0));
      chk({tag, " post_last"}, 128'(bus.rk_last), 128'(0));
      chk({tag, " post_idx"}, 128'(bus.rk_idx), 128'(10));
   endtask

   initial begin
      int t, early;
      fips = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
               128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
               128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
               128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
               128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      for (int k = 0; k < 11; k++) vecs[k] = '{K1, 0, k, fips[k]};
      vecs[11] = '{128'h0, 0, 1, Z1};
      vecs[12] = '{128'h0, 0, 10, Z10};
      for (int k = 0; k < 11; k++) vecs[13 + k] = '{K1, 1, k, fips[k]};

      bus.key_valid = 1'b0; bus.key = '0; bus.rk_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_valid", 128'(bus.rk_valid), 128'(0));
      chk("rst_rk", bus.rk, 128'h0);
      chk("rst_idx", 128'(bus.rk_idx), 128'(0));
      chk("rst_last", 128'(bus.rk_last), 128'(0));
      chk("rst_busy", 128'(bus.busy), 128'(0));
      rst = 1'b1;
      @(negedge clk);
      chk("rst_key_ready", 128'(bus.key_ready), 128'(1));

      // Abort mid-sequence at rk_idx 5
      bus.key = K1; bus.key_valid = 1'b1; bus.rk_ready = 1'b1;
      @(negedge clk);
      bus.key_valid = 1'b0;
      t = 0;
      while (!(bus.rk_valid && bus.rk_idx == 4'd5) && t < 50) begin @(negedge clk); t++; end
      chk("abort_reach_idx5", 128'(bus.rk_idx), 128'(5));
      chk("abort_rk5", bus.rk, fips[5]);
      rst = 1'b0;
      #1;
      chk("abort_valid", 128'(bus.rk_valid), 128'(0));
      chk("abort_rk", bus.rk, 128'h0);
      chk("abort_idx", 128'(bus.rk_idx), 128'(0));
      chk("abort_busy", 128'(bus.busy), 128'(0));
      bus.rk_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_key_ready", 128'(bus.key_ready), 128'(1));
      chk("abort_no_resume", 128'(bus.rk_valid), 128'(0));

      // Table-driven: FIPS key, zero key (rcon restarts at 01), FIPS key under stalls
      for (int i = 0; i < 24; i++) begin
         if (i == 0 || vecs[i].key !== vecs[i-1].key || vecs[i].mode != vecs[i-1].mode)
            run_key(vecs[i].key, vecs[i].mode, $sformatf("run%0d", i));
         chk($sformatf("vec%0d_rk%0d", i, vecs[i].idx), got[vecs[i].idx], vecs[i].exp);
      end

`ifdef AES_KEYEXP_STORE_EN
      rd_idx = 4'd10; #1;
      chk("store_rd10", rd_rk, fips[10]);
      rd_idx = 4'd11; #1;
      chk("store_rd11", rd_rk, 128'h0);
      rd_idx = 4'd4; #1;
      chk("store_rd4", rd_rk, fips[4]);
`endif

      // key_valid held during busy: K2 waits until the cycle after the last handshake
      @(negedge clk);
      bus.key = K1; bus.key_valid = 1'b1; bus.rk_ready = 1'b1;
      @(negedge clk);
      bus.key = K2;
      chk("hold_first_rk", bus.rk, K1);
      chk("hold_busy", 128'(bus.busy), 128'(1));
`ifdef AES_KEYEXP_STORE_EN
      rd_idx = 4'd3; #1;
      chk("store_cleared_rd3", rd_rk, 128'h0);
      rd_idx = 4'd0; #1;
      chk("store_rd0_new", rd_rk, K1);
`endif
      early = 0; t = 0;
      while (!(bus.rk_valid && bus.rk_last) && t < 50) begin
         if (bus.key_ready) early++;
         @(negedge clk); t++;
      end
      chk("hold_saw_last", 128'(bus.rk_last), 128'(1));
      chk("hold_last_rk", bus.rk, fips[10]);
      chk("hold_no_early_ready", 128'(early), 128'(0));
      chk("hold_ready_at_last", 128'(bus.key_ready), 128'(0));
      @(negedge clk);
      chk("hold_ready_after", 128'(bus.key_ready), 128'(1));
      chk("hold_valid_gap", 128'(bus.rk_valid), 128'(0));
      @(negedge clk);
      bus.key_valid = 1'b0;
      chk("hold_k2_valid", 128'(bus.rk_valid), 128'(1));
      chk("hold_k2_idx", 128'(bus.rk_idx), 128'(0));
      chk("hold_k2_rk", bus.rk, K2);
      t = 0;
      while (bus.rk_valid && t < 50) begin @(negedge clk); t++; end
      chk("hold_k2_drain", 128'(bus.rk_valid), 128'(0));
      bus.rk_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
